// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_control_unit_if : pipeline hazard signals (slave = controller)    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface hazard_control_unit_if;
  logic [31:0] instr_ID;
  logic [31:0] instr_EX;
  logic        memread_EX;
  logic        branch_taken_EX;
  logic        dmem_req_MEM;
  logic        dmem_ready_MEM;
  logic        pc_write_en;
  logic        ifid_write_en;
  logic        ifid_flush;
  logic        idex_write_en;
  logic        idex_flush;
  logic        exmem_write_en;
  logic        memwb_bubble;
  logic        mem_timeout_err;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;

  modport master (
    output instr_ID, instr_EX, memread_EX, branch_taken_EX, dmem_req_MEM, dmem_ready_MEM,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_flush,
           exmem_write_en, memwb_bubble, mem_timeout_err, perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  instr_ID, instr_EX, memread_EX, branch_taken_EX, dmem_req_MEM, dmem_ready_MEM,
    output pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_flush,
           exmem_write_en, memwb_bubble, mem_timeout_err, perf_stall_cycles, perf_flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_control_unit : RV32I stall/flush control with MEM-wait watchdog    |
// | Revision 1.0 -- perf counters under `HAZARD_PERF_CNT_EN                   |
// +--------------------------------------------------------------------------+
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  hazard_control_unit_if.slave   bus
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_ERR      = 2'd2;

  localparam logic [6:0]       c_OP_LUI   = 7'b0110111;
  localparam logic [6:0]       c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0]       c_OP_JAL   = 7'b1101111;
  localparam logic [6:0]       c_OP_REG   = 7'b0110011;
  localparam logic [6:0]       c_OP_STORE = 7'b0100011;
  localparam logic [6:0]       c_OP_BR    = 7'b1100011;
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       r_state, w_state_next, w_state_eff;
  logic [CNT_W-1:0] r_wait_cnt, w_cnt_next, w_cnt_inc;
  logic             w_rs1_used, w_rs2_used, w_load_use, w_mem_busy, w_freeze, w_branch_flush;
  logic             w_unused_bits;

  wire logic [6:0] w_op_id  = bus.instr_ID[6:0];
  wire logic [4:0] w_rs1_id = bus.instr_ID[19:15];
  wire logic [4:0] w_rs2_id = bus.instr_ID[24:20];
  wire logic [4:0] w_rd_ex  = bus.instr_EX[11:7];

  assign w_unused_bits = ^{bus.instr_ID[31:25], bus.instr_ID[14:7], bus.instr_EX[31:12], bus.instr_EX[6:0]};

  always_comb begin
    w_rs1_used = !((w_op_id == c_OP_LUI) || (w_op_id == c_OP_AUIPC) || (w_op_id == c_OP_JAL));
    w_rs2_used = (w_op_id == c_OP_REG) || (w_op_id == c_OP_STORE) || (w_op_id == c_OP_BR);
    w_load_use = bus.memread_EX && (w_rd_ex != 5'd0) &&
                 ((w_rs1_used && (w_rd_ex == w_rs1_id)) || (w_rs2_used && (w_rd_ex == w_rs2_id)));
    w_mem_busy = bus.dmem_req_MEM && !bus.dmem_ready_MEM;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_cnt_next;
    end
  end

  // Next-state logic; the counter holds the number of wait cycles completed so far
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_wait_cnt;
    w_cnt_inc    = r_wait_cnt + CNT_W'(1);
    case (r_state)
      S_RUN: begin
        if (w_mem_busy) begin
          w_cnt_next   = CNT_W'(1);
          w_state_next = (MEM_TIMEOUT == 1) ? S_ERR : S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus.dmem_ready_MEM) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
          if ((MEM_TIMEOUT != 0) && (w_cnt_inc == c_TIMEOUT)) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_RUN;
    endcase
  end

  // Mealy outputs; while reset is asserted the controller behaves as if in RUN
  always_comb begin
    w_state_eff    = rst_n ? r_state : S_RUN;
    w_freeze       = ((w_state_eff == S_RUN) && w_mem_busy) ||
                     ((w_state_eff == S_MEM_WAIT) && !bus.dmem_ready_MEM) ||
                     (w_state_eff == S_ERR);
    w_branch_flush = 1'b0;
    bus.pc_write_en    = 1'b1;
    bus.ifid_write_en  = 1'b1;
    bus.ifid_flush     = 1'b0;
    bus.idex_write_en  = 1'b1;
    bus.idex_flush     = 1'b0;
    bus.exmem_write_en = 1'b1;
    bus.memwb_bubble   = 1'b0;
    if (w_freeze) begin
      bus.pc_write_en    = 1'b0;
      bus.ifid_write_en  = 1'b0;
      bus.idex_write_en  = 1'b0;
      bus.exmem_write_en = 1'b0;
      bus.memwb_bubble   = 1'b1;
    end else if (bus.branch_taken_EX) begin
      w_branch_flush = 1'b1;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (w_load_use) begin
      bus.pc_write_en   = 1'b0;
      bus.ifid_write_en = 1'b0;
      bus.idex_flush    = 1'b1;
    end
    bus.mem_timeout_err = (w_state_eff == S_ERR);
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!bus.pc_write_en) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_branch_flush)   r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = r_stall_cnt;
  assign bus.perf_flush_count  = r_flush_cnt;
`else
  assign bus.perf_stall_cycles = 32'd0;
  assign bus.perf_flush_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_control_unit : directed scoreboard bench for hazard_control_unit|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_hazard_control_unit;

  localparam logic [31:0] c_LW_X5    = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] c_LW_X0    = 32'h0000A003;  // lw   x0,0(x1)
  localparam logic [31:0] c_ADD_X5X7 = 32'h00728333;  // add  x6,x5,x7
  localparam logic [31:0] c_ADD_X0X0 = 32'h00000333;  // add  x6,x0,x0
  localparam logic [31:0] c_LUI_X5   = 32'h000282B7;  // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] c_ADDI     = 32'h00538313;  // addi x6,x7,5 (rs2 field = 5)
  localparam logic [31:0] c_SW_X5    = 32'h00512023;  // sw   x5,0(x2)
  localparam logic [31:0] c_JAL_RS5  = 32'h0002806F;  // jal  with rs1 field = 5
  localparam logic [31:0] c_NOP      = 32'h00000013;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_bubble}
  localparam logic [6:0] c_DEF = 7'b1101010;
  localparam logic [6:0] c_LU  = 7'b0001110;
  localparam logic [6:0] c_BR  = 7'b1111110;
  localparam logic [6:0] c_FZ  = 7'b0000001;

  typedef struct {
    string       tag;
    logic [6:0]  ctrl;
    logic        err;
    logic        chk_err;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  exp_t sb[$];

  hazard_control_unit_if bus();

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_head();
    exp_t e;
    logic [6:0] obs;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e   = sb.pop_front();
    obs = {bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush, bus.idex_write_en,
           bus.idex_flush, bus.exmem_write_en, bus.memwb_bubble};
    n_vec++;
    assert (obs === e.ctrl) else begin
      n_err++;
      $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs, e.ctrl);
    end
    if (e.chk_err) begin
      n_vec++;
      assert (bus.mem_timeout_err === e.err) else begin
        n_err++;
        $error("FAIL %s err: observed %b expected %b", e.tag, bus.mem_timeout_err, e.err);
      end
    end
    n_vec++;
    assert (bus.perf_stall_cycles === e.stall) else begin
      n_err++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, bus.perf_stall_cycles, e.stall);
    end
    n_vec++;
    assert (bus.perf_flush_count === e.flush) else begin
      n_err++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", e.tag, bus.perf_flush_count, e.flush);
    end
  endtask

  task automatic step(input string tag, input logic rn, input logic [31:0] id, input logic [31:0] ex,
                      input logic mr, input logic br, input logic req, input logic rdy,
                      input logic [6:0] ctrl, input logic err, input logic chk_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = rn;
    bus.instr_ID        = id;
    bus.instr_EX        = ex;
    bus.memread_EX      = mr;
    bus.branch_taken_EX = br;
    bus.dmem_req_MEM    = req;
    bus.dmem_ready_MEM  = rdy;
    e.tag = tag; e.ctrl = ctrl; e.err = err; e.chk_err = chk_err;
    e.stall = m_stall; e.flush = m_flush;
    sb.push_back(e);
    @(negedge clk);
    check_head();
    if (!rn) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (!ctrl[6]) m_stall = m_stall + 32'd1;
      if (ctrl[4])  m_flush = m_flush + 32'd1;
`endif
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_stall = 32'd0; m_flush = 32'd0;
    rst_n = 1'b0;
    bus.instr_ID = c_NOP; bus.instr_EX = c_NOP; bus.memread_EX = 1'b0;
    bus.branch_taken_EX = 1'b0; bus.dmem_req_MEM = 1'b0; bus.dmem_ready_MEM = 1'b0;
    repeat (2) @(posedge clk);

    step("reset",       1'b0, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    step("idle",        1'b1, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    step("lu_rs1",      1'b1, c_ADD_X5X7, c_LW_X5,    1, 0, 0, 0, c_LU,  0, 1);
    step("lu_after",    1'b1, c_ADD_X5X7, c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    step("lw_x0",       1'b1, c_ADD_X0X0, c_LW_X0,    1, 0, 0, 0, c_DEF, 0, 1);
    step("lui_no_rs1",  1'b1, c_LUI_X5,   c_LW_X5,    1, 0, 0, 0, c_DEF, 0, 1);
    step("addi_no_rs2", 1'b1, c_ADDI,     c_LW_X5,    1, 0, 0, 0, c_DEF, 0, 1);
    step("lu_rs2_sw",   1'b1, c_SW_X5,    c_LW_X5,    1, 0, 0, 0, c_LU,  0, 1);
    step("jal_no_rs1",  1'b1, c_JAL_RS5,  c_LW_X5,    1, 0, 0, 0, c_DEF, 0, 1);
    step("not_load",    1'b1, c_ADD_X5X7, c_LW_X5,    0, 0, 0, 0, c_DEF, 0, 1);
    step("br_and_lu",   1'b1, c_ADD_X5X7, c_LW_X5,    1, 1, 0, 0, c_BR,  0, 1);
    step("br_only",     1'b1, c_NOP,      c_NOP,      0, 1, 0, 0, c_BR,  0, 1);
    // Memory wait of three cycles; hazards on the inputs must be ignored while frozen
    step("mw1",         1'b1, c_ADD_X5X7, c_LW_X5,    1, 1, 1, 0, c_FZ,  0, 1);
    step("mw2",         1'b1, c_ADD_X5X7, c_LW_X5,    1, 0, 1, 0, c_FZ,  0, 1);
    step("mw3",         1'b1, c_ADD_X5X7, c_LW_X5,    1, 0, 1, 0, c_FZ,  0, 1);
    step("mw_release",  1'b1, c_ADD_X5X7, c_LW_X5,    1, 0, 1, 1, c_LU,  0, 1);
    step("run_again",   1'b1, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    step("req_ready",   1'b1, c_NOP,      c_NOP,      0, 0, 1, 1, c_DEF, 0, 1);
    // Watchdog with MEM_TIMEOUT = 4
    step("wd1",         1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("wd2",         1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("wd3",         1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("wd4",         1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("err_set",     1'b1, c_NOP,      c_NOP,      0, 1, 0, 1, c_FZ,  1, 1);
    step("err_sticky",  1'b1, c_ADD_X5X7, c_LW_X5,    1, 0, 1, 1, c_FZ,  1, 1);
    step("err_rst",     1'b0, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 0);
    step("after_rst",   1'b1, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    // Reset during the second wait cycle, with the request dropped
    step("mid1",        1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("mid2",        1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("mid_rst",     1'b0, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 0);
    step("mid_after",   1'b1, c_NOP,      c_NOP,      0, 0, 0, 0, c_DEF, 0, 1);
    step("mid_rerun",   1'b1, c_NOP,      c_NOP,      0, 0, 1, 0, c_FZ,  0, 1);
    step("mid_rel",     1'b1, c_NOP,      c_NOP,      0, 0, 1, 1, c_DEF, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
